mmio_host_monitor: RTL

- Synthesizable memory-mapped host/test-status peripheral that snoops the core data-memory bus (same signals as the Pipeline mem_* port).
- Provides a console byte FIFO with a valid/ready drain, test-result decoding (pass/fail/tohost exit) and a watchdog timeout.
- Replaces hard-wired simulation checks, so the same test programs run on FPGA and in simulation.

---
 rtl/mmio_host_monitor_if.sv | 30 +++
 rtl/mmio_host_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mmio_host_monitor_if.sv
// Bus bundle for mmio_host_monitor: snooped data-memory port, console drain and status outputs.
// The monitor connects through the slave modport; the bus/host side uses master.
interface mmio_host_monitor_if;
    logic        mem_valid;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [7:0]  exit_code;
    logic [15:0] dropped;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport slave (
        input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr, tx_ready,
        output tx_valid, tx_data, done, pass, fail, timeout, exit_code, dropped, rd_valid, rd_data
    );

    modport master (
        output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr, tx_ready,
        input  tx_valid, tx_data, done, pass, fail, timeout, exit_code, dropped, rd_valid, rd_data
    );
endinterface

// File: rtl/mmio_host_monitor.sv
// Host/test-status monitor: snoops data-memory writes for console bytes, test result and tohost exit,
// with a watchdog. Optional status readback at ADDR_RESULT+4 is enabled by macro HOSTMON_READBACK_EN.
module mmio_host_monitor #(
    parameter logic [31:0] ADDR_PUTCHAR   = 32'h1000_0000,
    parameter logic [31:0] ADDR_RESULT    = 32'h1000_1000,
    parameter logic [31:0] ADDR_TOHOST    = 32'h0000_1000,
    parameter logic [7:0]  PASS_CODE      = 8'h03,
    parameter int          FIFO_LOG       = 4,
    parameter int          TIMEOUT_CYCLES = 20000
) (
    input  logic                  clk,
    input  logic                  rstn,
    mmio_host_monitor_if.slave    bus
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_PASS    = 3'd1,
        S_FAIL    = 3'd2,
        S_EXIT    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam logic        WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WDOG_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_exit_code, w_exit_nxt;
    logic              r_done, r_pass, r_fail, r_timeout;
    logic [31:0]       r_wdog;
    logic [FIFO_LOG:0] r_wr_ptr, r_rd_ptr;
    logic [7:0]        r_mem [0:(1<<FIFO_LOG)-1];
    logic [15:0]       r_dropped;
    logic              w_wr_en, w_hit_put, w_hit_res, w_hit_toh, w_run, w_expire;
    logic              w_empty, w_full, w_pop, w_push_req, w_push, w_drop;
    logic [7:0]        w_byte;
    logic              w_unused;

    assign w_byte     = bus.mem_wdata[7:0];
    assign w_wr_en    = bus.mem_valid & bus.mem_write & bus.mem_wmask[0];
    assign w_hit_put  = w_wr_en & (bus.mem_addr == ADDR_PUTCHAR);
    assign w_hit_res  = w_wr_en & (bus.mem_addr == ADDR_RESULT);
    assign w_hit_toh  = w_wr_en & (bus.mem_addr == ADDR_TOHOST);
    assign w_run      = (r_state == S_RUN);
    assign w_expire   = WDOG_EN & (r_wdog == WDOG_LAST);
    assign w_unused   = ^{bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

    // Full when pointers differ only in the wrap bit.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[FIFO_LOG] != r_rd_ptr[FIFO_LOG]) &&
                        (r_wr_ptr[FIFO_LOG-1:0] == r_rd_ptr[FIFO_LOG-1:0]);
    assign w_pop      = ~w_empty & bus.tx_ready;
    assign w_push_req = w_hit_put & w_run;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // Next-state and exit-code selection; a result/tohost hit beats watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_exit_nxt  = r_exit_code;
        case (r_state)
            S_RUN: begin
                if (w_hit_res) begin
                    w_state_nxt = (w_byte == PASS_CODE) ? S_PASS : S_FAIL;
                    w_exit_nxt  = w_byte;
                end else if (w_hit_toh) begin
                    w_state_nxt = S_EXIT;
                    w_exit_nxt  = w_byte;
                end else if (w_expire) begin
                    w_state_nxt = S_TIMEOUT;
                    w_exit_nxt  = 8'h00;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    // State register plus registered status flags decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_RUN;
            r_exit_code <= 8'h00;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exit_code <= w_exit_nxt;
            r_done      <= (w_state_nxt != S_RUN);
            r_pass      <= (w_state_nxt == S_PASS);
            r_fail      <= (w_state_nxt == S_FAIL);
            r_timeout   <= (w_state_nxt == S_TIMEOUT);
        end
    end

    // Watchdog counts only while running, so it freezes once the test terminates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog <= 32'd0;
        end else if (WDOG_EN && w_run) begin
            r_wdog <= r_wdog + 32'd1;
        end else begin
            r_wdog <= r_wdog;
        end
    end

    // FIFO pointers and saturating overflow counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_dropped <= 16'h0000;
        end else begin
            r_wr_ptr  <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr  <= w_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end else begin
                r_dropped <= r_dropped;
            end
        end
    end

    // FIFO storage; stale contents are never visible because tx_data is gated by empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_LOG-1:0]] <= w_byte;
        end
    end

    assign bus.tx_valid  = ~w_empty;
    assign bus.tx_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr[FIFO_LOG-1:0]];
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail      = r_fail;
    assign bus.timeout   = r_timeout;
    assign bus.exit_code = r_exit_code;
    assign bus.dropped   = r_dropped;

`ifdef HOSTMON_READBACK_EN
    logic        r_rd_valid;
    logic [31:0] r_rd_data;
    logic        w_rd_hit;

    assign w_rd_hit = bus.mem_valid & ~bus.mem_write & (bus.mem_addr == (ADDR_RESULT + 32'd4));

    // Status snapshot taken from the pre-edge register values of the request cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= 32'h0000_0000;
        end else begin
            r_rd_valid <= w_rd_hit;
            if (w_rd_hit) begin
                r_rd_data <= {r_dropped, r_exit_code, 4'b0000, r_timeout, r_fail, r_pass, r_done};
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
`else
    assign bus.rd_valid = 1'b0;
    assign bus.rd_data  = 32'h0000_0000;
`endif

endmodule
